// File: rtl/prod_accum.sv
// prod_accum: sums groups of LEN signed products and queues finished sums in a small valid/ready FIFO.
module prod_accum #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 18,
    parameter int LEN    = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [5:0]        grp_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state, state_n;
    logic [ACC_W-1:0]  acc, acc_n, base, sext, nsum;
    logic [5:0]        cnt_n;
    logic              ovf_q, ovf_n, grp_ovf, ovf_now, accept, last, pop;
    logic [ACC_W-1:0]  sum_mem [DEPTH];
    logic              ovf_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    assign in_ready  = !rst && !clr && (fifo_cnt != CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign base      = state == ACCUM ? acc : '0;
    assign grp_ovf   = state == ACCUM && ovf_q;
    assign sext      = ACC_W'($signed(in_product));
    assign nsum      = base + sext;
    assign ovf_now   = (base[ACC_W-1] == sext[ACC_W-1]) && (nsum[ACC_W-1] != base[ACC_W-1]);
    assign last      = accept && (6'(grp_cnt + 6'd1) == 6'(LEN));
    assign out_valid = fifo_cnt != '0;
    assign pop       = out_valid && out_ready;
    assign out_sum   = sum_mem[rd_ptr];
    assign out_ovf   = ovf_mem[rd_ptr];

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = grp_cnt;
        ovf_n   = ovf_q;
        if (clr) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end else if (accept) begin
            state_n = last ? IDLE : ACCUM;
            acc_n   = last ? '0 : nsum;
            cnt_n   = last ? '0 : 6'(grp_cnt + 6'd1);
            ovf_n   = last ? 1'b0 : grp_ovf | ovf_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            grp_cnt <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            grp_cnt <= cnt_n;
            ovf_q   <= ovf_n;
        end
    end

    // The finished group is written on the same edge that accepts its last product.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sum_mem[i] <= '0;
                ovf_mem[i] <= 1'b0;
            end
        end else begin
            if (last) begin
                sum_mem[wr_ptr] <= nsum;
                ovf_mem[wr_ptr] <= grp_ovf | ovf_now;
                wr_ptr          <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(last) - CW'(pop);
        end
    end
endmodule
